flasher_led_monitor: RTL
========================

Name: flasher_led_monitor

Overview:
- Passive observer on the 16-bit LED bus driven by bound_flasher; consumes led[15:0] on the same clock.
- Decodes the thermometer-coded bus into a lit-LED level and tracks rise/fall direction.
- Reports peak and trough events, sequence completion and aborts, and protocol errors.
- Used as an in-system checker and as the scoreboard front-end for flasher regressions.

Parameters:
- STALL_MAX, 64, cycles at level 0 in FALL before the sequence is declared aborted (≥2).
- CNT_W, 8, width of the event counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- led  input  16  observed LED bus; led[0] lights first.
- clr_err  input  1  clears the sticky error flags.
- level  output  5  lit-LED count, 0..16.
- state  output  2  0=IDLE, 1=RISE, 2=FALL.
- peak_vld  output  1  1-cycle pulse on a RISE→FALL reversal.
- peak_lvl  output  5  level at the last peak; held between pulses.
- trough_vld  output  1  1-cycle pulse on a FALL→RISE reversal.
- trough_lvl  output  5  level at the last trough; held between pulses.
- seq_done  output  1  1-cycle pulse when a complete sequence ends.
- seq_abort  output  1  1-cycle pulse on a stall at 0.
- ev_cnt  output  CNT_W  peaks plus troughs in the current sequence; saturates.
- err_therm  output  1  sticky: non-thermometer pattern seen.
- err_step  output  1  sticky: level changed by more than 1 in one cycle.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state=IDLE; internal max_seen=0, stall counter=0.
- Timing: all outputs are registered. led sampled at edge k is reflected in level, state and event pulses after edge k (1-cycle latency).
- Decode: led is valid iff led == 2^n−1 for n in 0..16, giving level n.
  - Invalid pattern: set err_therm; level, state and counters hold.
  - The next valid sample is compared against the held level.
- Step check: on a valid sample, if |n − level| > 1, set err_step. The new level is still accepted and the FSM is evaluated normally.
- max_seen tracks the highest level since leaving IDLE.
- FSM:
  - IDLE: n > level → RISE; clear ev_cnt and max_seen. n == level → stay.
  - RISE: n < level → FALL; peak_vld=1, peak_lvl=level (old value), ev_cnt+1. Otherwise stay.
  - FALL, n > level → RISE; trough_vld=1, trough_lvl=level, ev_cnt+1.
  - FALL, n == 0 with max_seen == 16 → IDLE; seq_done=1, no trough event.
  - FALL, n == 0 with max_seen < 16 → stay in FALL; stall counter runs while n == 0.
  - FALL, stall counter reaches STALL_MAX−1 → IDLE; seq_abort=1, no trough event.
  - FALL, any nonzero n → stall counter clears.
- Equal consecutive levels never change direction (flasher hold cycles are legal).
- Sticky errors:
  - Set by their condition, cleared only by clr_err.
  - If set and clear occur in the same cycle, set wins.
  - Errors never alter FSM progress.
- ev_cnt saturates at all-ones.
- Mid-sequence DUT reset (led jumps to 0): err_step is set; FALL at 0 with max_seen < 16 leads to seq_abort after STALL_MAX cycles.
- seq_done and seq_abort are mutually exclusive. At most one of peak_vld/trough_vld pulses per cycle.

Test Plan:
- Normal flow: 1-LED steps 0→6→0→11→5→16→0 (0x003F, 0x07FF, 0x001F, 0xFFFF) → peaks 6, 11, 16; troughs 0, 5; ev_cnt=5; one seq_done; no errors; state=IDLE at end.
- Kickback: rise to 11, fall to 0, rise to 11 again, then 5→16→0 → extra peak 11 and trough 0 reported; ev_cnt=7; seq_done once.
- Invalid pattern: at level 3, drive 0x0005 for 1 cycle, then 0x000F → err_therm=1, level stays 3, then 4; err_step=0.
- Step jump: 0x0003 → 0x003F → err_step=1, level=6, state=RISE. Assert clr_err together with a new jump → err_step stays 1. Assert clr_err alone → 0.
- Abort: rise to 6, fall to 0, hold 0 for 64 cycles → seq_abort exactly 64 cycles after level first reads 0; state=IDLE; seq_done never asserts.
- Async reset mid-RISE at level 9 → all outputs 0 immediately, without waiting for a clock edge; a normal sequence afterwards completes cleanly.

Source files
------------

// File: rtl/flasher_led_monitor.sv
// flasher_led_monitor
// Passive observer of the 16-bit thermometer-coded LED bus of bound_flasher.
// Decodes the bus into a lit-LED level and tracks the rise/fall direction.
// Reports peaks, troughs, sequence completion and stall aborts, and keeps sticky
// protocol error flags.
// Every output is a flop. A led sample taken at edge k is visible after edge k.
// This block has no handshake. Every pulse output is high for exactly one cycle.
// The reader must consume it in that cycle.
module flasher_led_monitor #(
    parameter int STALL_MAX = 64,   // cycles at level 0 in FALL before abort (>= 2)
    parameter int CNT_W     = 8     // event counter width
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      led,
    input  logic             clr_err,
    output logic [4:0]       level,
    output logic [1:0]       state,
    output logic             peak_vld,
    output logic [4:0]       peak_lvl,
    output logic             trough_vld,
    output logic [4:0]       trough_lvl,
    output logic             seq_done,
    output logic             seq_abort,
    output logic [CNT_W-1:0] ev_cnt,
    output logic             err_therm,
    output logic             err_step
);

    // Stall counter only needs to reach STALL_MAX-1.
    localparam int STALL_W = (STALL_MAX > 2) ? $clog2(STALL_MAX) : 1;
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_MAX - 1);
    localparam logic [4:0] LVL_FULL = 5'd16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RISE = 2'd1,
        S_FALL = 2'd2
    } state_t;

    // Registered state and outputs.
    state_t             r_state;
    logic [4:0]         r_level;
    logic [4:0]         r_max_seen;
    logic [STALL_W-1:0] r_stall;
    logic               r_peak_vld;
    logic [4:0]         r_peak_lvl;
    logic               r_trough_vld;
    logic [4:0]         r_trough_lvl;
    logic               r_seq_done;
    logic               r_seq_abort;
    logic [CNT_W-1:0]   r_ev_cnt;
    logic               r_err_therm;
    logic               r_err_step;

    // Decode results.
    logic [15:0]        w_led_inc;
    logic               w_valid;
    logic [4:0]         w_n;
    logic               w_up;
    logic               w_down;
    logic [4:0]         w_diff;
    logic               w_step_err;

    // Next-state values.
    state_t             w_state_nx;
    logic [4:0]         w_level_nx;
    logic [4:0]         w_max_nx;
    logic [STALL_W-1:0] w_stall_nx;
    logic               w_peak;
    logic               w_trough;
    logic               w_done;
    logic               w_abort;
    logic [4:0]         w_peak_lvl_nx;
    logic [4:0]         w_trough_lvl_nx;
    logic               w_ev_inc;
    logic               w_ev_clr;

    // Thermometer decode.
    // A bus value of the form 2^n-1 has no bit in common with its increment.
    // The all-ones value wraps to 0 when incremented, so it is also accepted.
    always_comb begin
        w_led_inc = led + 16'd1;
        w_valid   = ((led & w_led_inc) == 16'd0);
        w_n       = 5'd0;
        for (int i = 0; i < 16; i++) begin
            w_n = w_n + {4'd0, led[i]};
        end
    end

    // Direction of the sample against the held level, and the step-size check.
    always_comb begin
        w_up       = (w_n > r_level);
        w_down     = (w_n < r_level);
        w_diff     = w_up ? (w_n - r_level) : (r_level - w_n);
        w_step_err = w_valid && (w_diff > 5'd1);
    end

    // FSM next state, event pulses and datapath updates.
    // An invalid sample leaves all of these at their hold values.
    always_comb begin
        w_state_nx      = r_state;
        w_level_nx      = r_level;
        w_max_nx        = r_max_seen;
        w_stall_nx      = r_stall;
        w_peak          = 1'b0;
        w_trough        = 1'b0;
        w_done          = 1'b0;
        w_abort         = 1'b0;
        w_peak_lvl_nx   = r_peak_lvl;
        w_trough_lvl_nx = r_trough_lvl;
        w_ev_inc        = 1'b0;
        w_ev_clr        = 1'b0;

        if (w_valid) begin
            w_level_nx = w_n;
            if (w_n > r_max_seen) begin
                w_max_nx = w_n;
            end

            case (r_state)
                S_IDLE: begin
                    w_stall_nx = '0;
                    if (w_up) begin
                        // A new sequence starts here, so its statistics restart.
                        w_state_nx = S_RISE;
                        w_ev_clr   = 1'b1;
                        w_max_nx   = w_n;
                    end
                end

                S_RISE: begin
                    w_stall_nx = '0;
                    if (w_down) begin
                        w_state_nx    = S_FALL;
                        w_peak        = 1'b1;
                        w_peak_lvl_nx = r_level;
                        w_ev_inc      = 1'b1;
                    end
                end

                S_FALL: begin
                    if (w_up) begin
                        w_state_nx      = S_RISE;
                        w_trough        = 1'b1;
                        w_trough_lvl_nx = r_level;
                        w_ev_inc        = 1'b1;
                        w_stall_nx      = '0;
                    end else if (w_n == 5'd0) begin
                        if (r_max_seen == LVL_FULL) begin
                            // The full bar was reached, so this fall to 0 completes the sequence.
                            w_state_nx = S_IDLE;
                            w_done     = 1'b1;
                            w_stall_nx = '0;
                        end else if (r_level == 5'd0) begin
                            // The stall counter advances once per cycle spent at level 0.
                            // The step from 1 down to 0 is not counted.
                            if (r_stall == STALL_LAST) begin
                                w_state_nx = S_IDLE;
                                w_abort    = 1'b1;
                                w_stall_nx = '0;
                            end else begin
                                w_stall_nx = r_stall + 1'b1;
                            end
                        end
                    end else begin
                        w_stall_nx = '0;
                    end
                end

                default: begin
                    w_state_nx = S_IDLE;
                    w_stall_nx = '0;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Level tracking, event outputs, saturating counter and sticky errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level      <= 5'd0;
            r_max_seen   <= 5'd0;
            r_stall      <= '0;
            r_peak_vld   <= 1'b0;
            r_peak_lvl   <= 5'd0;
            r_trough_vld <= 1'b0;
            r_trough_lvl <= 5'd0;
            r_seq_done   <= 1'b0;
            r_seq_abort  <= 1'b0;
            r_ev_cnt     <= '0;
            r_err_therm  <= 1'b0;
            r_err_step   <= 1'b0;
        end else begin
            r_level      <= w_level_nx;
            r_max_seen   <= w_max_nx;
            r_stall      <= w_stall_nx;
            r_peak_vld   <= w_peak;
            r_peak_lvl   <= w_peak_lvl_nx;
            r_trough_vld <= w_trough;
            r_trough_lvl <= w_trough_lvl_nx;
            r_seq_done   <= w_done;
            r_seq_abort  <= w_abort;
            if (w_ev_clr) begin
                r_ev_cnt <= '0;
            end else if (w_ev_inc && (r_ev_cnt != {CNT_W{1'b1}})) begin
                r_ev_cnt <= r_ev_cnt + 1'b1;
            end
            // If an error is set and cleared in the same cycle, the set wins.
            r_err_therm  <= !w_valid   || (r_err_therm && !clr_err);
            r_err_step   <= w_step_err || (r_err_step  && !clr_err);
        end
    end

    assign level      = r_level;
    assign state      = r_state;
    assign peak_vld   = r_peak_vld;
    assign peak_lvl   = r_peak_lvl;
    assign trough_vld = r_trough_vld;
    assign trough_lvl = r_trough_lvl;
    assign seq_done   = r_seq_done;
    assign seq_abort  = r_seq_abort;
    assign ev_cnt     = r_ev_cnt;
    assign err_therm  = r_err_therm;
    assign err_step   = r_err_step;

endmodule
